// File: rtl/sti_pixel_serializer.sv
// -----------------------------------------------------------------------------
// sti_pixel_serializer
//
// Serial transmitter and pixel-memory writer for the STI/DAC path.
// A word with format controls is accepted on load. It is shifted out one bit
// per cycle, then written back to a pixel memory as PW-bit pixels at
// consecutive, wrapping addresses. An end-of-stream frame zero-fills the rest
// of the memory and then raises pixel_finish, which holds until reset.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   load           frame request (taken only when ready=1)
//   ready          idle, load will be accepted on the next edge
//   pi_data        2*PW payload
//   pi_length      frame length code L, frame is (L+1)*PW bits
//   pi_fill        L=2/3: payload left-aligned (1) or right-aligned (0)
//   pi_msb         1 = frame MSB transmitted first, 0 = LSB first
//   pi_low         L=0: low half (1) or high half (0) of pi_data
//   pi_end         last frame; zero-fill memory afterwards
//   so_data        serial bit (0 when so_valid=0)
//   so_valid       serial bit valid
//   pixel_wr       pixel write strobe
//   pixel_addr     pixel write address
//   pixel_dataout  pixel write data
//   pixel_finish   memory complete
// -----------------------------------------------------------------------------
module sti_pixel_serializer #(
    parameter int PW = 8,
    parameter int AW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    output logic            ready,
    input  logic [2*PW-1:0] pi_data,
    input  logic [1:0]      pi_length,
    input  logic            pi_fill,
    input  logic            pi_msb,
    input  logic            pi_low,
    input  logic            pi_end,
    output logic            so_data,
    output logic            so_valid,
    output logic            pixel_wr,
    output logic [AW-1:0]   pixel_addr,
    output logic [PW-1:0]   pixel_dataout,
    output logic            pixel_finish
);

    localparam int FW = 4 * PW;
    localparam int CW = $clog2(FW) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WRITE,
        FILL,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [AW-1:0] waddr;
    logic [AW-1:0] waddr_n;

    // Captured frame, stored in transmit order: bit FW-1 goes out first.
    logic [FW-1:0] seq_r;
    logic [1:0]    len_r;
    logic          end_r;

    logic          accept;
    logic [CW-1:0] last_bit;
    logic [FW-1:0] seq_bit_sh;
    logic [FW-1:0] seq_pix_sh;

    logic          so_vld_p0;
    logic          so_data_p0;
    logic          wr_vld_p0;
    logic [AW-1:0] addr_p0;
    logic [PW-1:0] data_p0;
    logic          finish_p0;

    function automatic logic [FW-1:0] bit_reverse(input logic [FW-1:0] v);
        logic [FW-1:0] r;
        r = '0;
        for (int i = 0; i < FW; i++) begin
            r[i] = v[FW-1-i];
        end
        return r;
    endfunction

    // Build the frame from the captured controls and reorder it so that the
    // first bit to leave is at the top. Because pixels are formed from the
    // transmitted stream (earliest bit = pixel MSB), the same vector then
    // yields pixel k as a plain PW-bit slice from the top.
    function automatic logic [FW-1:0] build_seq(
        input logic [2*PW-1:0] data,
        input logic [1:0]      len,
        input logic            fill,
        input logic            msb,
        input logic            low
    );
        logic [FW-1:0] frame;
        frame = '0;
        case (len)
            2'd0: frame[PW-1:0] = low ? data[PW-1:0] : data[2*PW-1:PW];
            2'd1: frame[2*PW-1:0] = data;
            2'd2: begin
                if (fill) frame[3*PW-1:PW] = data;
                else      frame[2*PW-1:0]  = data;
            end
            default: begin
                if (fill) frame[4*PW-1:2*PW] = data;
                else      frame[2*PW-1:0]    = data;
            end
        endcase
        // MSB-first: left-align the N-bit frame. LSB-first: full reversal
        // puts frame bit 0 on top and leaves the unused bits below.
        if (msb) return frame << ((3 - 32'(len)) * PW);
        else     return bit_reverse(frame);
    endfunction

    assign accept     = load & ready;
    assign last_bit   = CW'((32'(len_r) + 1) * PW - 1);
    assign seq_bit_sh = seq_r << cnt;
    assign seq_pix_sh = seq_r << (32'(cnt) * PW);

    // Frame capture: data registers, loaded only on an accepted request.
    always_ff @(posedge clk) begin
        if (accept) begin
            seq_r <= build_seq(pi_data, pi_length, pi_fill, pi_msb, pi_low);
            len_r <= pi_length;
            end_r <= pi_end;
        end
    end

    // Stage p0: next-state and combinational output values.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        waddr_n    = waddr;
        so_vld_p0  = 1'b0;
        so_data_p0 = 1'b0;
        wr_vld_p0  = 1'b0;
        addr_p0    = pixel_addr;
        data_p0    = '0;
        finish_p0  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                end
            end

            SHIFT: begin
                so_vld_p0  = 1'b1;
                so_data_p0 = seq_bit_sh[FW-1];
                if (cnt == last_bit) begin
                    state_n = WRITE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            WRITE: begin
                wr_vld_p0 = 1'b1;
                addr_p0   = waddr;
                data_p0   = seq_pix_sh[FW-1 -: PW];
                waddr_n   = waddr + 1'b1;
                if (cnt == CW'(len_r)) begin
                    cnt_n = '0;
                    if (!end_r)              state_n = IDLE;
                    else if (waddr_n == '0)  state_n = DONE;
                    else                     state_n = FILL;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            FILL: begin
                wr_vld_p0 = 1'b1;
                addr_p0   = waddr;
                waddr_n   = waddr + 1'b1;
                if (&waddr) state_n = DONE;
            end

            DONE: begin
                finish_p0 = 1'b1;
                addr_p0   = '0;
            end

            default: state_n = IDLE;
        endcase
    end

    // Stage p1: registered state and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            waddr         <= '0;
            ready         <= 1'b1;
            so_valid      <= 1'b0;
            so_data       <= 1'b0;
            pixel_wr      <= 1'b0;
            pixel_addr    <= '0;
            pixel_dataout <= '0;
            pixel_finish  <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            waddr         <= waddr_n;
            // Outputs trail the state by one cycle, so ready follows an
            // IDLE state that has already been seen for a full cycle.
            ready         <= (state == IDLE) && !accept;
            so_valid      <= so_vld_p0;
            so_data       <= so_data_p0;
            pixel_wr      <= wr_vld_p0;
            pixel_addr    <= addr_p0;
            pixel_dataout <= data_p0;
            pixel_finish  <= finish_p0;
        end
    end

endmodule

// File: tb/tb_sti_pixel_serializer.sv
module tb_sti_pixel_serializer;

    localparam int PW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic            clk = 1'b0;
    logic            reset;
    logic            load;
    logic            ready;
    logic [2*PW-1:0] pi_data;
    logic [1:0]      pi_length;
    logic            pi_fill;
    logic            pi_msb;
    logic            pi_low;
    logic            pi_end;
    logic            so_data;
    logic            so_valid;
    logic            pixel_wr;
    logic [AW-1:0]   pixel_addr;
    logic [PW-1:0]   pixel_dataout;
    logic            pixel_finish;

    sti_pixel_serializer #(.PW(PW), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .ready        (ready),
        .pi_data      (pi_data),
        .pi_length    (pi_length),
        .pi_fill      (pi_fill),
        .pi_msb       (pi_msb),
        .pi_low       (pi_low),
        .pi_end       (pi_end),
        .so_data      (so_data),
        .so_valid     (so_valid),
        .pixel_wr     (pixel_wr),
        .pixel_addr   (pixel_addr),
        .pixel_dataout(pixel_dataout),
        .pixel_finish (pixel_finish)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int c; int b;} bit_t;
    typedef struct {int c; int a; int d;} wr_t;

    bit_t qb[$];
    wr_t  qw[$];
    bit_t eb;
    wr_t  ew;

    int checks = 0;
    int errors = 0;

    int m_addr     = 0;
    int prev_a     = 0;
    int prev_ret   = 0;
    bit prev_valid = 1'b0;
    int exp_fin    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: compares every presented output against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (so_valid) begin
                if (qb.size() == 0) begin
                    chk("so_unexpected", int'(so_valid), 0);
                end else begin
                    eb = qb.pop_front();
                    chk("so_data", int'(so_data), eb.b);
                    chk("so_cycle", cyc, eb.c);
                end
            end else if (so_data !== 1'b0) begin
                chk("so_data_idle", int'(so_data), 0);
            end
            if (pixel_wr) begin
                if (qw.size() == 0) begin
                    chk("wr_unexpected", int'(pixel_wr), 0);
                end else begin
                    ew = qw.pop_front();
                    chk("wr_addr", int'(pixel_addr), ew.a);
                    chk("wr_data", int'(pixel_dataout), ew.d);
                    chk("wr_cycle", cyc, ew.c);
                end
            end
        end
    end

    // Reference model: frame as a number, transmitted stream as a bit list,
    // pixels as consecutive PW-bit groups of that list (first bit = MSB).
    task automatic model_frame(input int a, input logic [15:0] d, input logic [1:0] l,
                               input bit f, input bit m, input bit lo, input bit e);
        logic [31:0] frame;
        bit          s[$];
        int          n;
        int          p;
        int          pix;
        int          j;
        p = int'(l) + 1;
        n = p * PW;
        case (l)
            2'd0:    frame = lo ? 32'(d[7:0]) : 32'(d[15:8]);
            2'd1:    frame = 32'(d);
            2'd2:    frame = f ? 32'(d) * 256 : 32'(d);
            default: frame = f ? 32'(d) * 65536 : 32'(d);
        endcase
        for (int i = 0; i < n; i++) begin
            s.push_back(m ? frame[n-1-i] : frame[i]);
            qb.push_back('{a + 1 + i, int'(s[i])});
        end
        for (int k = 0; k < p; k++) begin
            pix = 0;
            for (int b = 0; b < PW; b++) pix = pix * 2 + int'(s[k*PW+b]);
            qw.push_back('{a + n + 1 + k, m_addr, pix});
            m_addr = (m_addr + 1) % DEPTH;
        end
        if (e) begin
            j = 0;
            while (m_addr != 0) begin
                qw.push_back('{a + n + p + 1 + j, m_addr, 0});
                m_addr = (m_addr + 1) % DEPTH;
                j++;
            end
            exp_fin = a + n + p + j + 1;
        end
        prev_a     = a;
        prev_ret   = n + p + 1;
        prev_valid = !e;
    endtask

    task automatic garbage();
        pi_data   = 16'($urandom);
        pi_length = 2'($urandom);
        pi_fill   = 1'($urandom);
        pi_msb    = 1'($urandom);
        pi_low    = 1'($urandom);
        pi_end    = 1'($urandom);
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] l, input bit f,
                        input bit m, input bit lo, input bit e, input int gap,
                        input bit noise);
        int t;
        int a;
        t = 0;
        do begin
            @(negedge clk);
            if (!ready) begin
                t++;
                if (noise) begin
                    load = 1'($urandom);
                    garbage();
                end
            end
        end while (!ready && t < 300);
        load = 1'b0;
        if (!ready) begin
            chk("ready_timeout", int'(ready), 1);
            return;
        end
        if (prev_valid) chk("ready_return", cyc, prev_a + prev_ret);
        repeat (gap) @(negedge clk);
        pi_data   = d;
        pi_length = l;
        pi_fill   = f;
        pi_msb    = m;
        pi_low    = lo;
        pi_end    = e;
        load      = 1'b1;
        @(posedge clk);
        #1;
        a    = cyc;
        load = 1'b0;
        garbage();
        model_frame(a, d, l, f, m, lo, e);
        @(negedge clk);
        chk("ready_drop", int'(ready), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, int'(ready), 1);
        chk({tag, "_so_valid"}, int'(so_valid), 0);
        chk({tag, "_so_data"}, int'(so_data), 0);
        chk({tag, "_pixel_wr"}, int'(pixel_wr), 0);
        chk({tag, "_pixel_addr"}, int'(pixel_addr), 0);
        chk({tag, "_pixel_dataout"}, int'(pixel_dataout), 0);
        chk({tag, "_pixel_finish"}, int'(pixel_finish), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        qb.delete();
        qw.delete();
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        reset      = 1'b0;
        m_addr     = 0;
        prev_valid = 1'b0;
    endtask

    task automatic wait_finish();
        int t;
        t = 0;
        while (!pixel_finish && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("finish_seen", int'(pixel_finish), 1);
        chk("finish_cycle", cyc, exp_fin);
        chk("finish_queue_empty", qw.size(), 0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((qb.size() != 0 || qw.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", qb.size() + qw.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        pi_data = '0; pi_length = '0; pi_fill = 1'b0;
        pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        // Directed frames filling addresses 0..9, then end frame with fill.
        send(16'hA55A, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        send(16'h1234, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        send(16'hBEEF, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        send(16'hBEEF, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        send(16'hFFFF, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
        wait_finish();
        for (int i = 0; i < 5; i++) begin
            load = 1'b1;
            garbage();
            @(negedge clk);
            chk("done_ready", int'(ready), 0);
            chk("done_finish", int'(pixel_finish), 1);
            chk("done_addr", int'(pixel_addr), 0);
        end
        load = 1'b0;

        // Random non-end frames with stray loads while busy; wraps 255->0.
        do_reset();
        for (int i = 0; i < 150; i++) begin
            send(16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'b0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b1);
        end
        drain();

        // Exactly 256 pixels, last frame end=1: straight to finish, no fill.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            send(16'($urandom), 2'd3, 1'($urandom), 1'($urandom), 1'b0,
                 (i == 63), 0, 1'b1);
        end
        wait_finish();

        // Reset while bit 5 of an L=3 frame is on the line.
        do_reset();
        send(16'($urandom), 2'd3, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 0, 0);
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b1;
        qb.delete();
        qw.delete();
        #1;
        check_idle_outputs("midshift_reset");
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        m_addr     = 0;
        prev_valid = 1'b0;
        send(16'h5A3C, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        drain();

        chk("final_so_queue", qb.size(), 0);
        chk("final_wr_queue", qw.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sti_pixel_serializer.md
# sti_pixel_serializer

Parametrised serial-transmit and pixel-memory writer for the STI/DAC path. It accepts a word with format controls and transmits 1–4 pixels' worth of bits serially on `so_data`/`so_valid`. It then writes the same bit stream, regrouped into pixels, to a pixel memory at consecutive addresses. On the end-of-stream frame it zero-fills the rest of the memory and raises `pixel_finish`. Pixel width and memory depth are generic, and a `ready` handshake allows back-to-back frames.

## Interface
- `PW`, default 8: pixel width in bits; input word is 2*PW, max frame 4*PW.
- `AW`, default 8: pixel address width; memory depth 2^AW.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `load` in 1: frame request; accepted only on an edge where `ready`=1.
- `ready` out 1: block idle and able to accept `load`.
- `pi_data` in 2*PW: payload.
- `pi_length` in 2: frame length code L; frame is N=(L+1)*PW bits.
- `pi_fill` in 1: for L=2/3, payload left-aligned (1) or right-aligned (0).
- `pi_msb` in 1: 1 = transmit frame MSB first; 0 = LSB first.
- `pi_low` in 1: for L=0, selects `pi_data[PW-1:0]` (1) or `pi_data[2PW-1:PW]` (0).
- `pi_end` in 1: this frame is the last; zero-fill memory afterwards.
- `so_data` out 1: serial bit.
- `so_valid` out 1: `so_data` valid.
- `pixel_wr` out 1: pixel write strobe.
- `pixel_addr` out AW: write address.
- `pixel_dataout` out PW: write data.
- `pixel_finish` out 1: memory complete; held until reset.

## Operation
- States: IDLE, SHIFT, WRITE, FILL, DONE.
  - IDLE: `ready`=1.
  - `load` in IDLE: capture all pi_* inputs into registers, build the frame, go to SHIFT. pi_* are ignored at every other time.
- Frame content by L:
  - L=0: the selected PW-bit half of `pi_data`.
  - L=1: `pi_data`.
  - L=2: fill ? {pi_data, PW'b0} : {PW'b0, pi_data}.
  - L=3: fill ? {pi_data, 2PW'b0} : {2PW'b0, pi_data}.
- SHIFT: exactly N cycles with `so_valid`=1. Bits go out from frame bit N-1 down to 0 if msb, else from bit 0 upward. Transition to WRITE after the N-th bit.
- Pixel regrouping: pixel k is transmitted bits k*PW .. k*PW+PW-1. The earliest-transmitted bit is the pixel MSB.
- WRITE: N/PW consecutive cycles, `pixel_wr`=1, one pixel per cycle in order k=0.. . `pixel_addr` increments by 1 after each write and wraps modulo 2^AW.
- After WRITE:
  - captured end=0: go to IDLE.
  - captured end=1 and next address ≠ 0: go to FILL.
  - captured end=1 and next address = 0: go directly to DONE.
- FILL: one write per cycle with `pixel_dataout`=0, from the next address up to and including 2^AW-1, then go to DONE.
- DONE: `pixel_finish`=1, `ready`=0, all other outputs 0. The block leaves DONE only on reset.
- `pixel_addr` persists across frames. Only reset clears it.

## Timing
- Reset values: `so_data`, `so_valid`, `pixel_wr`, `pixel_dataout`, `pixel_addr`, `pixel_finish` = 0; `ready`=1; state IDLE. All take effect immediately on reset assertion, including mid-SHIFT, mid-WRITE or mid-FILL. No partial frame resumes.
- `load` accepted at edge t0:
  - `ready` drops at t0.
  - `so_valid`=1 during cycles t0+1 .. t0+N.
  - `pixel_wr`=1 during cycles t0+N+1 .. t0+N+N/PW.
  - `ready`=1 from cycle t0+N+N/PW+1, unless going to FILL or DONE.
- `so_valid`/`so_data` and `pixel_wr`/`pixel_addr`/`pixel_dataout` are registered outputs. `so_data`=0 when `so_valid`=0. `pixel_dataout` is defined only while `pixel_wr`=1.
- Back-to-back: a `load` on the first `ready` cycle starts the next SHIFT one cycle later. There are no idle gaps beyond that.
- `load` while `ready`=0: ignored, no side effects.
- `pixel_finish` rises the cycle after the last FILL write, or after the last WRITE if no fill is needed.

## Test plan
- PW=8, AW=8. L=0, low=0, msb=1, data 16'hA55A: `so_data` 1,0,1,0,0,1,0,1 over 8 cycles; then one write addr 0 data 8'hA5; `ready` returns 10 cycles after accept.
- L=1, msb=0, data 16'h1234: 16 serial bits, LSB of 0x1234 first; writes addr 0 = 8'h2C, addr 1 = 8'h48.
- Two back-to-back loads:
  - L=3, fill=1, msb=1, data 16'hBEEF: writes BE, EF, 00, 00 at addrs 0–3.
  - L=2, fill=0, msb=1, data 16'hBEEF: writes 00, BE, EF at addrs 4–6.
  - Exactly one idle `ready` cycle between the two frames.
- Frames writing addrs 0–9, then L=1, end=1, data 16'hFFFF: writes FF, FF at 10–11; zeros at 12–255 (244 writes); then `pixel_finish`=1; a subsequent `load` is ignored.
- Fill 256 pixels exactly with the last frame end=1: no FILL writes, `pixel_finish` the cycle after the last write. Separately, a non-end frame crossing 255→0 wraps the address.
- Assert `reset` during SHIFT bit 5 of an L=3 frame: all outputs 0 and `ready`=1 immediately; a new L=0 frame then writes to addr 0.
